// File: rtl/pwm_demodulator.sv
// PWM duty-cycle demodulator: measures high time over 2^W-cycle windows aligned
// to PWM rising edges and publishes one saturated W-bit sample per window.
module pwm_demodulator #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         PWM_in,
  output logic [W-1:0] dataOut,
  output logic         valid,
  output logic         locked
);

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    MEASURE
  } stateE;

  localparam logic [W-1:0] LAST = '1;

  stateE                  state;
  logic [SYNC_STAGES-1:0] syncReg;
  logic                   sD;
  logic [W-1:0]           wcnt;
  logic [W:0]             hcnt;
  logic [W-1:0]           tcnt;
  logic                   edge0;
  logic                   mismatch;

  logic                   s;
  logic                   rise;
  logic                   lastCycle;
  logic                   edge0Now;
  logic                   mismatchNow;
  logic [W:0]             hcntNext;
  logic [W-1:0]           sample;

  assign s           = syncReg[SYNC_STAGES-1];
  assign rise        = s & ~sD;
  assign lastCycle   = (wcnt == LAST);
  assign edge0Now    = edge0 | (rise & (wcnt == '0));
  assign mismatchNow = mismatch | (rise & (wcnt != '0));
  assign hcntNext    = hcnt + (W+1)'(s);
  // A fully high window counts 2^W cycles, which does not fit in W bits.
  assign sample      = hcntNext[W] ? LAST : hcntNext[W-1:0];

  // NOTE: every register here uses <= so all updates see the pre-edge values;
  // blocking assignments would make the result depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      syncReg  <= '0;
      sD       <= 1'b0;
      wcnt     <= '0;
      hcnt     <= '0;
      tcnt     <= '0;
      edge0    <= 1'b0;
      mismatch <= 1'b0;
      dataOut  <= '0;
      valid    <= 1'b0;
      locked   <= 1'b0;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], PWM_in};
      sD      <= s;
      valid   <= 1'b0;
      if (!en) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= SEEK;
            tcnt  <= '0;
          end
          SEEK: begin
            tcnt <= tcnt + W'(1);
            if (rise) begin
              // The rise cycle itself is window cycle 0 and is already high.
              state    <= MEASURE;
              wcnt     <= W'(1);
              hcnt     <= (W+1)'(1);
              edge0    <= 1'b1;
              mismatch <= 1'b0;
            end else if (tcnt == LAST) begin
              state    <= MEASURE;
              wcnt     <= '0;
              hcnt     <= '0;
              edge0    <= 1'b0;
              mismatch <= 1'b0;
            end
          end
          MEASURE: begin
            wcnt     <= wcnt + W'(1);
            hcnt     <= hcntNext;
            edge0    <= edge0Now;
            mismatch <= mismatchNow;
            if (lastCycle) begin
              dataOut  <= sample;
              valid    <= 1'b1;
              locked   <= edge0Now & ~mismatchNow;
              hcnt     <= '0;
              edge0    <= 1'b0;
              mismatch <= 1'b0;
              if (mismatchNow) begin
                state <= SEEK;
                tcnt  <= '0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
